dbus_bridge: RTL and testbench

Data-bus bridge between the combinational `mem` (LSU) stage and the external data memory/peripheral bus. It captures the LSU's chip-enable request and drives it onto a registered req/ack bus. It holds the pipeline via `stall_req_o` until the access completes, and presents the read word back to the LSU for byte/halfword extraction. A timeout counter turns a hung bus into a one-cycle `bus_err_o` pulse for the ctrl module.

---
 rtl/dbus_bridge.sv | 133 +++++++++++++
 tb/tb_dbus_bridge.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dbus_bridge.sv
// dbus_bridge
//   Registered req/ack bridge between the LSU (mem stage) and the external
//   data bus. The LSU chip-enable is captured into the bus fields. The
//   pipeline is stalled until the access completes. The read word is held
//   for the LSU until the next read ack. A hung bus is converted into a
//   one-cycle bus_err_o pulse after TIMEOUT_CYCLES request cycles.
//
// Ports
//   clk_i, n_rst_i          clock, async active-low reset
//   mem_ce_i/we/a/sel/wd    LSU request
//   mem_rd_o                read word back to the LSU
//   advance_i, flush_i      ctrl: mem stage advances / pipeline flush
//   stall_req_o             stall request to ctrl (combinational)
//   bus_err_o               one-cycle timeout pulse
//   bus_req/we/addr/sel/wdata_o  registered bus request fields
//   bus_rdata_i, bus_ack_i  bus completion
module dbus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_a_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_wd_i,
  output logic [31:0] mem_rd_o,
  input  logic        advance_i,
  input  logic        flush_i,
  output logic        stall_req_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  localparam int unsigned CW     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          TO_EN  = (TIMEOUT_CYCLES != 0);
  // Terminal count. With the timeout disabled the counter just saturates
  // at all-ones and is never compared.
  localparam logic [CW-1:0] TERM = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          drop_q, drop_d;
  logic [CW-1:0] cnt_q;
  logic          start, ack_hit, to_hit, drop_now;

  // ---------------- next-state ----------------
  always_comb begin
    state_d  = state_q;
    drop_d   = drop_q;
    start    = 1'b0;
    ack_hit  = 1'b0;
    to_hit   = 1'b0;
    // A flush in the same cycle as the ack/timeout must also drop the result.
    drop_now = drop_q | flush_i;
    unique case (state_q)
      S_IDLE: begin
        if (mem_ce_i && !flush_i) begin
          start   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        drop_d = drop_now;
        if (bus_ack_i) begin
          ack_hit = 1'b1;
          state_d = drop_now ? S_IDLE : S_DONE;
        end else if (TO_EN && cnt_q == TERM) begin
          to_hit  = 1'b1;
          state_d = drop_now ? S_IDLE : S_DONE;
        end
      end
      S_DONE: begin
        if (advance_i || flush_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) drop_d = 1'b0;
  end

  assign stall_req_o = n_rst_i &
                       (((state_q == S_IDLE) & mem_ce_i & ~flush_i) | (state_q == S_REQ));

  // ---------------- state register ----------------
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_sel_o   <= '0;
      bus_wdata_o <= '0;
      mem_rd_o    <= '0;
      bus_err_o   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      bus_err_o <= to_hit;
      if (start) begin
        bus_req_o   <= 1'b1;
        bus_we_o    <= mem_we_i;
        bus_addr_o  <= mem_a_i;
        bus_sel_o   <= mem_sel_i;
        bus_wdata_o <= mem_wd_i;
        cnt_q       <= '0;
      end else if (state_q == S_REQ) begin
        // Bus fields stay as captured; only req is dropped on completion.
        if (ack_hit || to_hit)  bus_req_o <= 1'b0;
        else if (cnt_q != TERM) cnt_q     <= cnt_q + CW'(1);
      end
      // A flushed read never overwrites the word the LSU may still hold.
      if (ack_hit && !bus_we_o && !drop_now) mem_rd_o <= bus_rdata_i;
      if (to_hit)                            mem_rd_o <= '0;
    end
  end

endmodule

// File: tb/tb_dbus_bridge.sv
module tb_dbus_bridge;

  logic        clk_i = 1'b0;
  logic        n_rst_i;
  logic        mem_ce_i, mem_we_i;
  logic [31:0] mem_a_i, mem_wd_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_rd_o;
  logic        advance_i, flush_i;
  logic        stall_req_o, bus_err_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;

  int checks = 0;
  int errors = 0;

  dbus_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .n_rst_i(n_rst_i),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_a_i(mem_a_i),
    .mem_sel_i(mem_sel_i), .mem_wd_i(mem_wd_i), .mem_rd_o(mem_rd_o),
    .advance_i(advance_i), .flush_i(flush_i),
    .stall_req_o(stall_req_o), .bus_err_o(bus_err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change 1ns after the rising edge; checks run 1ns later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    n_rst_i = 1'b0; mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_a_i = 32'hFFFF_FFFF;
    mem_sel_i = 4'hF; mem_wd_i = 32'hFFFF_FFFF; advance_i = 1'b0; flush_i = 1'b0;
    bus_rdata_i = 32'h0; bus_ack_i = 1'b0;
    tick(); tick(); #1;
    checks++; if (stall_req_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", stall_req_o); end
    checks++; if ({bus_req_o, bus_we_o, bus_err_o} !== 3'b000) begin errors++; $display("FAIL reset_ctl: got %b exp 000", {bus_req_o, bus_we_o, bus_err_o}); end
    checks++; if ({bus_addr_o, bus_wdata_o, bus_sel_o, mem_rd_o} !== 100'h0) begin errors++; $display("FAIL reset_data: got %h/%h/%h/%h exp 0", bus_addr_o, bus_wdata_o, bus_sel_o, mem_rd_o); end
    mem_ce_i = 1'b0; mem_we_i = 1'b0;
    tick(); n_rst_i = 1'b1;
  endtask

  task automatic test_zero_wait_read();
    tick(); mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_a_i = 32'h1000; mem_sel_i = 4'hF; #1;
    checks++; if ({stall_req_o, bus_req_o} !== 2'b10) begin errors++; $display("FAIL zw_idle: got stall/req %b exp 10", {stall_req_o, bus_req_o}); end
    tick(); mem_ce_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'hDEAD_BEEF; #1;
    checks++; if ({stall_req_o, bus_req_o, bus_we_o} !== 3'b110) begin errors++; $display("FAIL zw_req: got stall/req/we %b exp 110", {stall_req_o, bus_req_o, bus_we_o}); end
    checks++; if (bus_addr_o !== 32'h1000) begin errors++; $display("FAIL zw_addr: got %h exp 00001000", bus_addr_o); end
    tick(); bus_ack_i = 1'b0; bus_rdata_i = 32'h0; advance_i = 1'b1; #1;
    checks++; if ({stall_req_o, bus_req_o} !== 2'b00) begin errors++; $display("FAIL zw_done: got stall/req %b exp 00", {stall_req_o, bus_req_o}); end
    checks++; if (mem_rd_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL zw_rdata: got %h exp deadbeef", mem_rd_o); end
    tick(); advance_i = 1'b0; #1;
    checks++; if ({stall_req_o, bus_req_o} !== 2'b00) begin errors++; $display("FAIL zw_after: got stall/req %b exp 00", {stall_req_o, bus_req_o}); end
  endtask

  task automatic test_waited_write();
    tick(); mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_a_i = 32'h2004; mem_sel_i = 4'hF; mem_wd_i = 32'h1234_5678; #1;
    checks++; if (stall_req_o !== 1'b1) begin errors++; $display("FAIL ww_idle_stall: got %b exp 1", stall_req_o); end
    for (int i = 0; i < 4; i++) begin
      // Scramble the LSU side: the bus must keep the captured fields.
      tick(); mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_a_i = 32'hAAAA_0000 + i; mem_wd_i = 32'h0; mem_sel_i = 4'h1;
      bus_ack_i = (i == 3); bus_rdata_i = 32'h9999_9999; #1;
      checks++; if ({stall_req_o, bus_req_o, bus_we_o} !== 3'b111) begin errors++; $display("FAIL ww_req%0d: got stall/req/we %b exp 111", i, {stall_req_o, bus_req_o, bus_we_o}); end
      checks++; if ({bus_addr_o, bus_sel_o, bus_wdata_o} !== {32'h2004, 4'hF, 32'h1234_5678}) begin errors++; $display("FAIL ww_fields%0d: got %h %h %h exp 00002004 f 12345678", i, bus_addr_o, bus_sel_o, bus_wdata_o); end
    end
    tick(); bus_ack_i = 1'b0; bus_rdata_i = 32'h0; #1;
    checks++; if ({stall_req_o, bus_req_o} !== 2'b00) begin errors++; $display("FAIL ww_done: got stall/req %b exp 00", {stall_req_o, bus_req_o}); end
    checks++; if (mem_rd_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ww_rd_kept: got %h exp deadbeef", mem_rd_o); end
    advance_i = 1'b1;
    tick(); advance_i = 1'b0;
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    int err_pulses = 0;
    tick(); mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_a_i = 32'h3000; #1;
    for (int i = 0; i < 8; i++) begin
      tick(); mem_ce_i = 1'b0; #1;
      if (bus_req_o) req_cycles++;
      if (bus_err_o) err_pulses++;
    end
    checks++; if (req_cycles !== 4) begin errors++; $display("FAIL to_req_cycles: got %0d exp 4", req_cycles); end
    checks++; if (err_pulses !== 1) begin errors++; $display("FAIL to_err_pulses: got %0d exp 1", err_pulses); end
    checks++; if (mem_rd_o !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h exp 0", mem_rd_o); end
    // Still parked in DONE: a pending request must not stall or issue.
    mem_ce_i = 1'b1; mem_a_i = 32'h3333_0000; #1;
    checks++; if ({stall_req_o, bus_req_o} !== 2'b00) begin errors++; $display("FAIL to_done: got stall/req %b exp 00", {stall_req_o, bus_req_o}); end
    mem_ce_i = 1'b0; advance_i = 1'b1;
    tick(); advance_i = 1'b0;
  endtask

  task automatic test_flush_req();
    tick(); mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_a_i = 32'h4000; #1;
    tick(); mem_ce_i = 1'b0; #1;
    checks++; if (bus_req_o !== 1'b1) begin errors++; $display("FAIL fl_req1: got %b exp 1", bus_req_o); end
    tick(); flush_i = 1'b1; #1;
    checks++; if ({stall_req_o, bus_req_o} !== 2'b11) begin errors++; $display("FAIL fl_req2: got stall/req %b exp 11", {stall_req_o, bus_req_o}); end
    tick(); flush_i = 1'b0; #1;
    checks++; if ({stall_req_o, bus_req_o} !== 2'b11) begin errors++; $display("FAIL fl_req3: got stall/req %b exp 11", {stall_req_o, bus_req_o}); end
    tick(); bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_F00D; #1;
    checks++; if ({stall_req_o, bus_req_o} !== 2'b11) begin errors++; $display("FAIL fl_req4: got stall/req %b exp 11", {stall_req_o, bus_req_o}); end
    tick(); bus_ack_i = 1'b0; bus_rdata_i = 32'h0; #1;
    checks++; if ({stall_req_o, bus_req_o} !== 2'b00) begin errors++; $display("FAIL fl_after: got stall/req %b exp 00", {stall_req_o, bus_req_o}); end
    checks++; if (mem_rd_o !== 32'h0) begin errors++; $display("FAIL fl_rdata: got %h exp 0", mem_rd_o); end
    // Only IDLE stalls on a fresh request; DONE would not.
    mem_ce_i = 1'b1; #1;
    checks++; if (stall_req_o !== 1'b1) begin errors++; $display("FAIL fl_idle: got stall %b exp 1", stall_req_o); end
    mem_ce_i = 1'b0; #1;
  endtask

  task automatic test_back_to_back();
    tick(); mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_a_i = 32'h6000; #1;
    tick(); mem_a_i = 32'h7000; bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_2222; #1;
    for (int i = 0; i < 4; i++) begin
      tick(); bus_ack_i = 1'b0; bus_rdata_i = 32'h0; advance_i = (i == 3); #1;
      checks++; if ({stall_req_o, bus_req_o} !== 2'b00) begin errors++; $display("FAIL bb_done%0d: got stall/req %b exp 00", i, {stall_req_o, bus_req_o}); end
      checks++; if (mem_rd_o !== 32'h1111_2222) begin errors++; $display("FAIL bb_hold%0d: got %h exp 11112222", i, mem_rd_o); end
    end
    tick(); advance_i = 1'b0; #1;
    checks++; if ({stall_req_o, bus_req_o} !== 2'b10) begin errors++; $display("FAIL bb_idle: got stall/req %b exp 10", {stall_req_o, bus_req_o}); end
    tick(); mem_ce_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h3333_4444; #1;
    checks++; if ({bus_req_o, bus_addr_o} !== {1'b1, 32'h7000}) begin errors++; $display("FAIL bb_req2: got req %b addr %h exp 1 00007000", bus_req_o, bus_addr_o); end
    tick(); bus_ack_i = 1'b0; bus_rdata_i = 32'h0; advance_i = 1'b1; #1;
    checks++; if (mem_rd_o !== 32'h3333_4444) begin errors++; $display("FAIL bb_rdata2: got %h exp 33334444", mem_rd_o); end
    tick(); advance_i = 1'b0;
  endtask

  task automatic test_async_reset();
    tick(); mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_a_i = 32'h8000; mem_wd_i = 32'h5555_5555; #1;
    tick(); mem_ce_i = 1'b0; mem_we_i = 1'b0; #1;
    tick(); #1;
    checks++; if (bus_req_o !== 1'b1) begin errors++; $display("FAIL ar_pre: got req %b exp 1", bus_req_o); end
    #1 n_rst_i = 1'b0; #1;
    checks++; if ({bus_req_o, stall_req_o, bus_we_o, bus_err_o} !== 4'b0000) begin errors++; $display("FAIL ar_ctl: got %b exp 0000", {bus_req_o, stall_req_o, bus_we_o, bus_err_o}); end
    checks++; if ({bus_addr_o, bus_wdata_o, bus_sel_o, mem_rd_o} !== 100'h0) begin errors++; $display("FAIL ar_data: got %h/%h/%h/%h exp 0", bus_addr_o, bus_wdata_o, bus_sel_o, mem_rd_o); end
    tick(); n_rst_i = 1'b1;
    tick(); mem_ce_i = 1'b1; mem_a_i = 32'h9000; #1;
    tick(); mem_ce_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h55AA_55AA; #1;
    checks++; if ({bus_req_o, bus_we_o, bus_addr_o} !== {2'b10, 32'h9000}) begin errors++; $display("FAIL ar_req: got req/we %b%b addr %h exp 10 00009000", bus_req_o, bus_we_o, bus_addr_o); end
    tick(); bus_ack_i = 1'b0; bus_rdata_i = 32'h0; advance_i = 1'b1; #1;
    checks++; if ({stall_req_o, mem_rd_o} !== {1'b0, 32'h55AA_55AA}) begin errors++; $display("FAIL ar_rdata: got stall %b rd %h exp 0 55aa55aa", stall_req_o, mem_rd_o); end
    tick(); advance_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_waited_write();
    test_timeout();
    test_flush_req();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
